pipe_fifo: RTL and testbench
============================

Name: pipe_fifo

Overview:
Parametrised inter-stage elastic buffer for the in-order RV64I pipeline. It generalises the single-entry fetch/decode/execute/memory stage registers into a DEPTH-entry valid/ready queue of arbitrary payload width. The first instance sits between fetch and decode and carries fetch_data_t: raw_instr, pc and valid, 97 bits. A synchronous flush discards wrong-path entries on branch/jump redirect.

Parameters:
DATA_W, 97, payload width in bits (default = width of fetch_data_t)
DEPTH, 4, number of entries; power of two, ≥ 2
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; do not override)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
flush  in  1  discard all entries (redirect from execute)
in_valid  in  1  producer offers in_data
in_ready  out  1  buffer can accept this cycle
in_data  in  DATA_W  payload from producer
out_valid  out  1  out_data holds a live entry
out_ready  in  1  consumer takes out_data this cycle
out_data  out  DATA_W  oldest entry
count  out  CNT_W  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- State: storage array mem[DEPTH], wr_ptr and rd_ptr of $clog2(DEPTH) bits, cnt of CNT_W bits.
- Reset (reset==0 at edge): wr_ptr=0, rd_ptr=0, cnt=0. mem is not reset.
- Outputs after reset: count=0, empty=1, full=0, in_ready=1, out_valid=0. out_data is don't-care while out_valid=0.
- in_ready = !full. It is not widened by a same-cycle pop; a full buffer stalls the producer for one cycle.
- out_valid = !empty && !flush.
- out_data = mem[rd_ptr], a combinational read of registered storage.
- push = in_valid && in_ready && !flush; pop = out_valid && out_ready.
- On push: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1.
- On pop: rd_ptr <= rd_ptr+1.
- Pointers wrap modulo DEPTH through natural overflow; no explicit compare.
- cnt: push only → +1; pop only → −1; both or neither → unchanged. Push and pop in the same cycle are legal when 0 < cnt < DEPTH.
- Full boundary: cnt never exceeds DEPTH, because in_ready=0 blocks the push.
- Empty boundary: cnt never goes below 0, because out_valid=0 blocks the pop.
- Latency: an entry pushed at edge N is visible at out_data during cycle N+1, provided it is the oldest entry.
- Flush (flush==1, reset==1): next state is wr_ptr=0, rd_ptr=0, cnt=0. Any same-cycle push is dropped. out_valid is forced to 0 in the flush cycle, so no pop occurs.
- Flush takes priority over push and pop. Reset takes priority over flush.
- Reset asserted mid-operation: all in-flight entries are lost and state returns to the reset values at the next edge.
- Protocol assumption: the producer holds in_valid and in_data stable until accepted. The buffer does not check this.

Optional Feature:
PIPE_FIFO_BYPASS_EN
- Defined: when empty && in_valid && !flush, out_valid=1 and out_data=in_data combinationally.
  - If out_ready is also 1, the item passes through with zero latency: not written to mem, pointers and cnt unchanged.
  - If out_ready is 0, the item is stored as a normal push.
- Not defined: no combinational in→out path. Minimum latency is 1 cycle and out_valid depends only on registered state and flush.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release → count=0, empty=1, in_ready=1, out_valid=0.
- Fill/drain order (out_ready=0): push 0x00000013, 0x00100093, 0x00200113, 0x00300193 with pc 0x80000000..0x8000000C → full=1, in_ready=0, count=4. Then out_ready=1 → four entries pop in order, one per cycle, empty=1 after the 4th.
- Simultaneous push/pop: hold count=2 with in_valid=out_ready=1 for 10 cycles using incrementing payloads → count stays 2. Output sequence equals input sequence delayed by 2 entries; pointers wrap twice with no corruption.
- Full stall: at count=4, in_valid=1 and out_ready=1 → pop occurs, push is refused (in_ready=0), count=3 next cycle. Following cycle the push is accepted.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 → out_valid=0 that cycle, no pop, push dropped, count=0 next cycle. A push after the flush emerges as the first entry.
- Bypass (PIPE_FIFO_BYPASS_EN defined): empty, in_valid=1, out_ready=1, in_data=0x...ABCD → out_valid=1 and out_data=0x...ABCD in the same cycle, count stays 0. Without the macro: out_valid=0 in that cycle and the data appears next cycle.

Source files
------------

// File: rtl/pipe_fifo.sv
// -----------------------------------------------------------------------------
// pipe_fifo
//
// Elastic valid/ready buffer placed between in-order pipeline stages. It
// replaces a single-entry stage register with a DEPTH-entry queue of arbitrary
// payload width. The first instance sits between fetch and decode and carries
// fetch_data_t {valid, pc[63:0], raw_instr[31:0]} (97 bits). A synchronous
// flush discards all wrong-path entries on a branch/jump redirect.
//
// Parameters
//   DATA_W  payload width in bits (default 97 = width of fetch_data_t)
//   DEPTH   number of entries; power of two, >= 2
//   CNT_W   occupancy count width, derived from DEPTH (not overridable)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      synchronous reset, active-low (0 = reset)
//   flush      discard all entries (redirect from execute)
//   in_valid   producer offers in_data
//   in_ready   buffer can accept this cycle (= !full)
//   in_data    payload from producer
//   out_valid  out_data holds a live entry
//   out_ready  consumer takes out_data this cycle
//   out_data   oldest entry (combinational read of registered storage)
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//
// Build option
//   PIPE_FIFO_BYPASS_EN  when defined, an offered item on an empty buffer is
//                        presented at out_data in the same cycle; if the
//                        consumer takes it, it never touches storage. When not
//                        defined there is no combinational in->out path and the
//                        minimum latency is one cycle.
// -----------------------------------------------------------------------------
module pipe_fifo #(
  parameter  int DATA_W = 97,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DATA_W-1:0] data_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  data_t mem_q [DEPTH];

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  cnt_q,    cnt_d;

  // Handshake qualifiers for the current cycle.
  logic  push;   // in_data is written into storage at the next edge
  logic  pop;    // the oldest stored entry is retired at the next edge

  // ---------------------------------------------------------------------------
  // Status outputs: purely a function of the registered occupancy.
  // ---------------------------------------------------------------------------
  always_comb begin
    count    = cnt_q;
    full     = (cnt_q == cnt_t'(DEPTH));
    empty    = (cnt_q == '0);
    // A full buffer refuses the producer even if the consumer pops this
    // cycle; this keeps in_ready off the out_ready timing path.
    in_ready = !full;
  end

  // ---------------------------------------------------------------------------
  // Output side and handshake qualification
  // ---------------------------------------------------------------------------
`ifdef PIPE_FIFO_BYPASS_EN
  logic byp_offer;   // empty buffer forwards the producer's item directly
  logic pass_thru;   // forwarded item is taken: no storage, no state change

  always_comb begin
    byp_offer = empty && in_valid && !flush;
    out_valid = (!empty && !flush) || byp_offer;
    // While empty, storage holds nothing live, so in_data is the only
    // candidate; otherwise the oldest stored entry wins.
    out_data  = empty ? in_data : mem_q[rd_ptr_q];
    pass_thru = byp_offer && out_ready;
    push      = in_valid && in_ready && !flush && !pass_thru;
    // A pass-through handshake must not move the read pointer.
    pop       = out_valid && out_ready && !empty;
  end
`else
  always_comb begin
    out_valid = !empty && !flush;
    out_data  = mem_q[rd_ptr_q];
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready;
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (flush) begin
      // Redirect: everything in flight is wrong-path. Flush outranks push
      // and pop (both are already masked by flush above).
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo
      // DEPTH through natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);

      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + cnt_t'(1);
        2'b01:   cnt_d = cnt_q - cnt_t'(1);
        default: cnt_d = cnt_q;   // both or neither: occupancy unchanged
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers (synchronous, active-low reset; reset outranks flush)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the payload array is deliberately not reset; the pointers and count
  // define which entries are live, and leaving it reset-free lets it map onto
  // plain flops or a RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_fifo.sv
// -----------------------------------------------------------------------------
// tb_pipe_fifo
//
// Scoreboard bench for pipe_fifo. A driver applies directed sequences and then
// randomized traffic; for every item the reference model says will be accepted
// it appends the payload to exp_q and tracks the expected occupancy as a plain
// integer. A separate monitor samples the DUT at the falling edge, checks the
// status outputs against the model occupancy, compares out_data against the
// head of exp_q whenever out_valid is high, and retires the head on a
// handshake.
// -----------------------------------------------------------------------------
module tb_pipe_fifo;

  localparam int DATA_W = 97;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

`ifdef PIPE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [DATA_W-1:0] data_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  data_t            in_data;
  logic             out_valid;
  logic             out_ready;
  data_t            out_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  pipe_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  int    errors     = 0;
  int    checks     = 0;
  data_t exp_q[$];          // payloads the model says the consumer will see
  int    model_cnt  = 0;    // occupancy during the current cycle
  int    model_next = 0;    // occupancy after the coming edge
  bit    chk_en     = 1'b0;

  task automatic check(input string name, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic data_t fetch_item(input logic [31:0] instr, input logic [63:0] pc);
    return {1'b1, pc, instr};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: mid-cycle sampling, away from the active edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    bit exp_ov;
    if (chk_en) begin
      exp_ov = !flush && ((model_cnt > 0) || (BYP && in_valid && model_cnt == 0));
      check("count",     data_t'(count),     data_t'(model_cnt));
      check("full",      data_t'(full),      data_t'(model_cnt == DEPTH));
      check("empty",     data_t'(empty),     data_t'(model_cnt == 0));
      check("in_ready",  data_t'(in_ready),  data_t'(model_cnt != DEPTH));
      check("out_valid", data_t'(out_valid), data_t'(exp_ov));
      if (reset && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data: got %h, expected no live entry (t=%0t)", out_data, $time);
        end else begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver + reference model. One call = one clock cycle of stimulus.
  // ---------------------------------------------------------------------------
  task automatic step(input bit rst_n, input bit fl, input bit iv, input data_t d,
                      input bit ordy, output bit acc);
    bit pass, push, pop;
    @(posedge clk);
    #1;
    if (reset === 1'b0) chk_en = 1'b1;   // state is known once a reset edge is seen
    model_cnt = model_next;
    reset     = rst_n;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    pass = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    if (!rst_n || fl) begin
      model_next = 0;
      exp_q.delete();
    end else begin
      pass = BYP && model_cnt == 0 && iv && ordy;
      push = iv && model_cnt < DEPTH && !pass;
      pop  = ordy && model_cnt > 0;
      if (pass || push) exp_q.push_back(d);
      model_next = model_cnt + int'(push) - int'(pop);
    end
    acc = rst_n && !fl && (pass || push);
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    step(1'b1, 1'b0, 1'b0, '0, ordy, acc);
  endtask

  task automatic push_one(input data_t d, input bit ordy);
    bit acc;
    step(1'b1, 1'b0, 1'b1, d, ordy, acc);
  endtask

  // Bounded by the model, which empties within DEPTH cycles of out_ready=1.
  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && model_next != 0; i++) idle(1'b1);
    idle(1'b0);
  endtask

  logic [31:0] instrs [4];
  data_t       pend;
  bit          pend_v;
  bit          acc;
  int          ready_pct;

  initial begin
    instrs[0] = 32'h0000_0013;
    instrs[1] = 32'h0010_0093;
    instrs[2] = 32'h0020_0113;
    instrs[3] = 32'h0030_0193;

    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset held for two edges, then idle.
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
    idle(1'b0);
    idle(1'b0);

    // Fill to full with consumer stalled, observe full, then drain in order.
    for (int i = 0; i < 4; i++) push_one(fetch_item(instrs[i], 64'h8000_0000 + 64'(4 * i)), 1'b0);
    idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);

    // Steady state at count=2 with push and pop every cycle; pointers wrap.
    push_one(data_t'(100), 1'b0);
    push_one(data_t'(101), 1'b0);
    for (int i = 0; i < 10; i++) push_one(data_t'(102 + i), 1'b1);
    drain();

    // Full stall: pop happens, push refused, then accepted on the next cycle.
    for (int i = 0; i < 4; i++) push_one(data_t'(200 + i), 1'b0);
    push_one(data_t'(204), 1'b1);
    push_one(data_t'(204), 1'b0);
    drain();

    // Flush with a simultaneous offer and ready; the next push is first out.
    for (int i = 0; i < 3; i++) push_one(data_t'(300 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, data_t'(303), 1'b1, acc);
    push_one(data_t'(304), 1'b0);
    drain();

    // Offer on an empty buffer with the consumer ready.
    push_one({1'b1, 64'h0, 32'h0000_ABCD}, 1'b1);
    idle(1'b1);
    drain();

    // Reset asserted mid-operation discards in-flight entries.
    push_one(data_t'(400), 1'b0);
    push_one(data_t'(401), 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
    push_one(data_t'(402), 1'b0);
    drain();

    // Randomized traffic; the producer holds an item until it is accepted.
    pend_v = 1'b0;
    pend   = '0;
    for (int blk = 0; blk < 15; blk++) begin
      ready_pct = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        if (!pend_v && $urandom_range(0, 99) < 70) begin
          pend   = data_t'({$urandom(), $urandom(), $urandom(), $urandom()});
          pend_v = 1'b1;
        end
        step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0), pend_v, pend,
             ($urandom_range(0, 99) < ready_pct), acc);
        if (acc) pend_v = 1'b0;
      end
    end

    drain();
    @(negedge clk);
    #1;
    check("scoreboard_empty", data_t'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
